// File: rtl/bkm_iter_ctrl.sv
// Iteration sequencer for the bkm_step datapath: accepts one request, steps n
// through the configured iteration count, then holds the result until consumed.
module bkm_iter_ctrl #(
  parameter int LOG2N = 6,
  parameter int WCNT  = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  input  logic [LOG2N-1:0] cfg_iters,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic             sel_init,
  output logic             step_en,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WCNT-1:0]  ops_done
);

  // state | meaning
  // IDLE  | waiting for a request, start_ready high
  // LOAD  | step 0, initial operands selected into bkm_step
  // RUN   | steps 1..last, fed-back registers selected
  // DONE  | final result held until done_ready
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [1:0]       fmt_q, fmt_d;
  logic [LOG2N-1:0] last_q, last_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [WCNT-1:0]  ops_q, ops_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      fmt_q   <= 2'b00;
      last_q  <= '0;
      n_q     <= '0;
      ops_q   <= '0;
    end else if (srst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      fmt_q   <= 2'b00;
      last_q  <= '0;
      n_q     <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fmt_q   <= fmt_d;
      last_q  <= last_d;
      n_q     <= n_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fmt_d   = fmt_q;
    last_d  = last_q;
    n_d     = n_q;
    ops_d   = ops_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            mode_d  = cfg_mode;
            fmt_d   = cfg_format;
            // a zero count wraps to all ones, i.e. the full 2^LOG2N steps
            last_d  = cfg_iters - LOG2N'(1);
            n_d     = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (last_q == '0) begin
            state_d = DONE;
          end else begin
            n_d     = LOG2N'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (n_q == last_q) state_d = DONE;
          else               n_d     = n_q + LOG2N'(1);
        end
        DONE: begin
          if (done_ready) begin
            state_d = IDLE;
            ops_d   = ops_q + WCNT'(1);
            n_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    sel_init    = (state_q == LOAD);
    step_en     = enable && ((state_q == LOAD) || (state_q == RUN));
    done_valid  = (state_q == DONE);
    step_mode   = mode_q;
    step_format = fmt_q;
    step_n      = n_q;
    ops_done    = ops_q;
  end

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Scoreboard bench for bkm_iter_ctrl: requests push expected step sequences,
// a negedge monitor follows each operation and checks every cycle.
module tb_bkm_iter_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       srst = 1'b0;
  logic       enable = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       cfg_mode = 1'b0;
  logic [1:0] cfg_format = 2'b00;
  logic [5:0] cfg_iters = 6'd0;
  logic       step_mode;
  logic [1:0] step_format;
  logic [5:0] step_n;
  logic       sel_init;
  logic       step_en;
  logic       busy;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [3:0] ops_done;

  bkm_iter_ctrl #(.LOG2N(6), .WCNT(4)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_mode(cfg_mode), .cfg_format(cfg_format), .cfg_iters(cfg_iters),
    .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
    .sel_init(sel_init), .step_en(step_en), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic       mode;
    logic [1:0] fmt;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         phase = 0;   // 0 idle, 1 stepping, 2 result held
  int         cnt = 0;     // step pulses seen in the current operation
  logic [3:0] exp_ops = 4'd0;
  bit         manual = 1'b1;
  int         en_pct = 100;
  int         dr_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_step_mode"}, step_mode, 0);
    chk({tag, "_step_format"}, step_format, 0);
    chk({tag, "_step_n"}, step_n, 0);
    chk({tag, "_sel_init"}, sel_init, 0);
    chk({tag, "_step_en"}, step_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_ops_done"}, ops_done, 0);
  endtask

  // Monitor: reference behaviour of one operation, followed cycle by cycle.
  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      chk_reset("arst_mon");
      phase = 0; cnt = 0; exp_ops = 4'd0; sb.delete();
    end else begin
      chk("ops_done", ops_done, exp_ops);
      case (phase)
        0: begin
          chk("idle_start_ready", start_ready, 1);
          chk("idle_busy", busy, 0);
          chk("idle_done_valid", done_valid, 0);
          chk("idle_step_en", step_en, 0);
          chk("idle_step_n", step_n, 0);
          chk("idle_sel_init", sel_init, 0);
          if (start_valid && enable) begin
            if (sb.size() == 0) chk("accept_without_request", 1, 0);
            else begin phase = 1; cnt = 0; end
          end
        end
        1: begin
          e = sb[0];
          chk("run_start_ready", start_ready, 0);
          chk("run_busy", busy, 1);
          chk("run_done_valid", done_valid, 0);
          chk("run_step_en", step_en, enable);
          chk("run_step_n", step_n, cnt);
          chk("run_sel_init", sel_init, (cnt == 0) ? 1 : 0);
          chk("run_step_mode", step_mode, e.mode);
          chk("run_step_format", step_format, e.fmt);
          if (enable) begin
            cnt++;
            if (cnt == e.k) phase = 2;
          end
        end
        default: begin
          e = sb[0];
          chk("done_start_ready", start_ready, 0);
          chk("done_busy", busy, 1);
          chk("done_valid", done_valid, 1);
          chk("done_step_en", step_en, 0);
          chk("done_step_n", step_n, e.k - 1);
          chk("done_sel_init", sel_init, 0);
          chk("done_step_mode", step_mode, e.mode);
          chk("done_step_format", step_format, e.fmt);
          if (done_ready && enable) begin
            void'(sb.pop_front());
            exp_ops = exp_ops + 4'd1;
            phase = 0;
          end
        end
      endcase
      if (srst) begin
        phase = 0; cnt = 0; exp_ops = 4'd0; sb.delete();
      end
    end
  end

  // Random enable/done_ready when not under direct control; config scrambled
  // whenever no request is pending so late changes must be ignored.
  always @(posedge clk) begin
    #2;
    if (!manual) begin
      enable     = ($urandom_range(99) < en_pct);
      done_ready = ($urandom_range(99) < dr_pct);
    end
    if (!start_valid) begin
      cfg_mode   = 1'($urandom_range(1));
      cfg_format = 2'($urandom_range(3));
      cfg_iters  = 6'($urandom_range(63));
    end
  end

  task automatic issue(input int it, input logic m, input logic [1:0] f);
    exp_t e;
    @(posedge clk); #2;
    cfg_iters   = it[5:0];
    cfg_mode    = m;
    cfg_format  = f;
    start_valid = 1'b1;
    e.k    = (it == 0) ? 64 : it;
    e.mode = m;
    e.fmt  = f;
    sb.push_back(e);
  endtask

  task automatic wait_accept(output int n);
    bit ok = 1'b0;
    n = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      n++;
      if (start_ready && enable) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge clk);
      if (sb.size() == 0 && phase == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_stepn(input int v);
    bit ok = 1'b0;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (step_n == v[5:0] && step_en) begin ok = 1'b1; break; end
    end
    if (!ok) chk("stepn_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (done_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int lat;
    #12;
    chk_reset("por");
    @(posedge clk); #3;
    arst = 1'b0;
    enable = 1'b1;
    done_ready = 1'b1;

    // normal three-step operation with latency check
    issue(3, 1'b1, 2'b10);
    wait_accept(n);
    lat = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      lat++;
      if (done_valid) break;
    end
    chk("latency_k3", lat, 4);
    wait_idle();
    chk("ops_after_first", ops_done, 1);

    // boundary counts
    issue(1, 1'b0, 2'b01);
    wait_accept(n);
    wait_idle();
    issue(0, 1'b1, 2'b11);
    wait_accept(n);
    wait_idle();

    // enable stall at step_n=2
    issue(5, 1'b0, 2'b10);
    wait_accept(n);
    wait_stepn(1);
    @(posedge clk); #2;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    enable = 1'b1;
    wait_idle();

    // backpressure with a request waiting during DONE
    done_ready = 1'b0;
    issue(2, 1'b1, 2'b01);
    wait_accept(n);
    wait_done();
    issue(3, 1'b0, 2'b11);
    repeat (3) @(posedge clk);
    #2;
    done_ready = 1'b1;
    wait_accept(n);
    chk("accept_after_done", n, 2);
    wait_idle();

    // async reset mid-RUN, then sync reset in the next operation
    issue(10, 1'b1, 2'b11);
    wait_accept(n);
    wait_stepn(4);
    #3;
    arst = 1'b1;
    #1;
    chk_reset("arst_now");
    @(negedge clk);
    @(posedge clk); #2;
    arst = 1'b0;
    issue(10, 1'b1, 2'b01);
    wait_accept(n);
    wait_stepn(4);
    @(posedge clk); #2;
    srst = 1'b1;
    @(posedge clk); #1;
    chk_reset("srst");
    #1;
    srst = 1'b0;

    // randomized traffic with stalls and backpressure
    manual = 1'b0;
    en_pct = 75;
    dr_pct = 60;
    for (int i = 0; i < 30; i++) begin
      int it;
      it = ($urandom_range(3) == 0) ? int'($urandom_range(63)) : int'($urandom_range(6, 1));
      issue(it, 1'($urandom_range(1)), 2'($urandom_range(3)));
      wait_accept(n);
    end
    wait_idle();

    // counter wrap: 17 operations on a 4-bit counter from reset
    @(posedge clk); #3;
    arst = 1'b1;
    @(negedge clk);
    @(posedge clk); #3;
    arst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      issue(int'($urandom_range(4, 1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
      wait_accept(n);
    end
    wait_idle();
    chk("ops_wrap", ops_done, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
